mem_arbiter: RTL and testbench

Two-master, single-slave memory arbiter that shares one single-port RAM (1-cycle registered read latency, per-byte write strobes) between the CPU memory port (master 0) and a second requester such as a program loader or DMA engine (master 1). It accepts one transaction at a time from either master over a req/ack handshake. It latches the winning request, drives the RAM for exactly one access cycle, and returns read data with a one-cycle ack pulse. It sits between the CPU/loader and the program/data RAM in the SoC top level.

---
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request port of the memory arbiter: one master's req/ack handshake and bus fields.
// The requester drives the master modport; the arbiter takes the slave modport.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    localparam int unsigned SW = DW / 8;

    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, addr, wdata, wstrb,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, wdata, wstrb,
        output ack, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master, single-slave RAM arbiter: one transaction at a time, fixed 4-cycle
// IDLE -> ACCESS -> RESP -> ACK sequence, round-robin or fixed-priority tie break.
module mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      m0,
    mem_arbiter_if.slave      m1,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_wstrb,
    output logic              s_rstrb,
    input  logic [DW-1:0]     s_rdata,
    output logic              busy,
    output logic              owner
);
    localparam int unsigned SW = DW / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] ACK    = 2'd3;

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_owner;
    logic          r_busy;
    logic          r_id;
    logic          r_rd;
    logic [AW-1:0] r_s_addr;
    logic [DW-1:0] r_s_wdata;
    logic [SW-1:0] r_s_wstrb;
    logic          r_s_rstrb;
    logic          r_m0_ack;
    logic          r_m1_ack;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic [1:0]    w_state_nxt;
    logic          w_last_grant_nxt;
    logic          w_owner_nxt;
    logic          w_busy_nxt;
    logic          w_id_nxt;
    logic          w_rd_nxt;
    logic [AW-1:0] w_s_addr_nxt;
    logic [DW-1:0] w_s_wdata_nxt;
    logic [SW-1:0] w_s_wstrb_nxt;
    logic          w_s_rstrb_nxt;
    logic          w_m0_ack_nxt;
    logic          w_m1_ack_nxt;
    logic [DW-1:0] w_m0_rdata_nxt;
    logic [DW-1:0] w_m1_rdata_nxt;

    logic          w_any_req;
    logic          w_win;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;
    logic [SW-1:0] w_win_wstrb;

    // Winner selection: a lone requester wins; a tie goes to master 0 or to the
    // master that was not granted last time.
    always_comb begin
        w_any_req = m0.req | m1.req;
        if (m0.req && m1.req) begin
            w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        end else begin
            w_win = m1.req;
        end
        w_win_addr  = w_win ? m1.addr  : m0.addr;
        w_win_wdata = w_win ? m1.wdata : m0.wdata;
        w_win_wstrb = w_win ? m1.wstrb : m0.wstrb;
    end

    // Next state and next registered outputs; slave bus is quiet outside ACCESS.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_owner_nxt      = r_owner;
        w_id_nxt         = r_id;
        w_rd_nxt         = r_rd;
        w_s_addr_nxt     = '0;
        w_s_wdata_nxt    = '0;
        w_s_wstrb_nxt    = '0;
        w_s_rstrb_nxt    = 1'b0;
        w_m0_ack_nxt     = 1'b0;
        w_m1_ack_nxt     = 1'b0;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt      = ACCESS;
                    w_id_nxt         = w_win;
                    w_last_grant_nxt = w_win;
                    w_owner_nxt      = w_win;
                    w_rd_nxt         = ~|w_win_wstrb;
                    w_s_addr_nxt     = w_win_addr;
                    w_s_wdata_nxt    = w_win_wdata;
                    if (|w_win_wstrb) begin
                        w_s_wstrb_nxt = w_win_wstrb;
                    end else begin
                        w_s_rstrb_nxt = 1'b1;
                    end
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_state_nxt = ACK;
                if (r_rd) begin
                    if (r_id) begin
                        w_m1_rdata_nxt = s_rdata;
                    end else begin
                        w_m0_rdata_nxt = s_rdata;
                    end
                end
                w_m0_ack_nxt = ~r_id;
                w_m1_ack_nxt = r_id;
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_id         <= 1'b0;
            r_rd         <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_s_wstrb    <= '0;
            r_s_rstrb    <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_busy       <= w_busy_nxt;
            r_id         <= w_id_nxt;
            r_rd         <= w_rd_nxt;
            r_s_addr     <= w_s_addr_nxt;
            r_s_wdata    <= w_s_wdata_nxt;
            r_s_wstrb    <= w_s_wstrb_nxt;
            r_s_rstrb    <= w_s_rstrb_nxt;
            r_m0_ack     <= w_m0_ack_nxt;
            r_m1_ack     <= w_m1_ack_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
        end
    end

    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wstrb  = r_s_wstrb;
    assign s_rstrb  = r_s_rstrb;
    assign busy     = r_busy;
    assign owner    = r_owner;
    assign m0.ack   = r_m0_ack;
    assign m0.rdata = r_m0_rdata;
    assign m1.ack   = r_m1_ack;
    assign m1.rdata = r_m1_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance, each on its own
// RAM, checked every cycle against a transaction-level model plus literal expectations.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int NLIT = 256;

    localparam int F_BUSY   = 0;
    localparam int F_OWNER  = 1;
    localparam int F_ACK0   = 2;
    localparam int F_ACK1   = 3;
    localparam int F_RD0    = 4;
    localparam int F_RD1    = 5;
    localparam int F_SADDR  = 6;
    localparam int F_SWDATA = 7;
    localparam int F_SWSTRB = 8;
    localparam int F_SRSTRB = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Master-side drive (index [dut][master]) and observed outputs.
    logic        d_req   [2][2];
    logic [31:0] d_addr  [2][2];
    logic [31:0] d_wdata [2][2];
    logic [3:0]  d_wstrb [2][2];
    logic        o_ack   [2][2];
    logic [31:0] o_rdata [2][2];
    logic [31:0] o_saddr [2];
    logic [31:0] o_swdata[2];
    logic [3:0]  o_swstrb[2];
    logic        o_srstrb[2];
    logic        o_busy  [2];
    logic        o_owner [2];
    logic [31:0] s_rdata [2];

    mem_arbiter_if #(.AW(AW), .DW(DW)) mif [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_if
        assign mif[g].req          = d_req[g/2][g%2];
        assign mif[g].addr         = d_addr[g/2][g%2];
        assign mif[g].wdata        = d_wdata[g/2][g%2];
        assign mif[g].wstrb        = d_wstrb[g/2][g%2];
        assign o_ack[g/2][g%2]     = mif[g].ack;
        assign o_rdata[g/2][g%2]   = mif[g].rdata;
    end

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .m0(mif[0]), .m1(mif[1]),
        .s_addr(o_saddr[0]), .s_wdata(o_swdata[0]), .s_wstrb(o_swstrb[0]),
        .s_rstrb(o_srstrb[0]), .s_rdata(s_rdata[0]),
        .busy(o_busy[0]), .owner(o_owner[0])
    );

    mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .m0(mif[2]), .m1(mif[3]),
        .s_addr(o_saddr[1]), .s_wdata(o_swdata[1]), .s_wstrb(o_swstrb[1]),
        .s_rstrb(o_srstrb[1]), .s_rdata(s_rdata[1]),
        .busy(o_busy[1]), .owner(o_owner[1])
    );

    // RAMs: registered read, per-byte write, plus a backdoor load port.
    logic [31:0] ram [2][64];
    logic        bd_en;
    int          bd_k;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_srstrb[k]) s_rdata[k] <= ram[k][o_saddr[k][7:2]];
            for (int b = 0; b < 4; b++) begin
                if (o_swstrb[k][b]) ram[k][o_saddr[k][7:2]][8*b +: 8] <= o_swdata[k][8*b +: 8];
            end
        end
        if (bd_en) ram[bd_k][bd_idx] <= bd_val;
    end

    // Literal expectations queued by the stimulus, checked by the compare process.
    int          lit_cyc[NLIT];
    int          lit_k  [NLIT];
    int          lit_f  [NLIT];
    logic [31:0] lit_v  [NLIT];
    int          lit_n = 0;

    int  cyc = 0;
    int  n_tot = 0;
    int  n_bad = 0;
    logic chk_en = 1'b0;

    // Model state: cycles since grant (0 = idle), the granted transaction, memory image.
    int          mph  [2];
    logic        mwin [2];
    logic        mrd  [2];
    logic [31:0] maddr[2];
    logic [31:0] mwd  [2];
    logic [3:0]  mws  [2];
    logic        mlast[2];
    logic        mown [2];
    logic [31:0] mpend[2];
    logic [31:0] mrdata[2][2];
    logic [31:0] mmem [2][64];

    function automatic string fname(int f);
        case (f)
            F_BUSY:   return "busy";
            F_OWNER:  return "owner";
            F_ACK0:   return "m0_ack";
            F_ACK1:   return "m1_ack";
            F_RD0:    return "m0_rdata";
            F_RD1:    return "m1_rdata";
            F_SADDR:  return "s_addr";
            F_SWDATA: return "s_wdata";
            F_SWSTRB: return "s_wstrb";
            default:  return "s_rstrb";
        endcase
    endfunction

    function automatic logic [31:0] act_of(int k, int f);
        case (f)
            F_BUSY:   return 32'(o_busy[k]);
            F_OWNER:  return 32'(o_owner[k]);
            F_ACK0:   return 32'(o_ack[k][0]);
            F_ACK1:   return 32'(o_ack[k][1]);
            F_RD0:    return o_rdata[k][0];
            F_RD1:    return o_rdata[k][1];
            F_SADDR:  return o_saddr[k];
            F_SWDATA: return o_swdata[k];
            F_SWSTRB: return 32'(o_swstrb[k]);
            default:  return 32'(o_srstrb[k]);
        endcase
    endfunction

    function automatic logic [31:0] exp_of(int k, int f);
        logic act1;
        act1 = (mph[k] == 1);
        case (f)
            F_BUSY:   return 32'(mph[k] != 0);
            F_OWNER:  return 32'(mown[k]);
            F_ACK0:   return 32'(mph[k] == 3 && mwin[k] == 1'b0);
            F_ACK1:   return 32'(mph[k] == 3 && mwin[k] == 1'b1);
            F_RD0:    return mrdata[k][0];
            F_RD1:    return mrdata[k][1];
            F_SADDR:  return act1 ? maddr[k] : 32'h0;
            F_SWDATA: return act1 ? mwd[k] : 32'h0;
            F_SWSTRB: return (act1 && !mrd[k]) ? 32'(mws[k]) : 32'h0;
            default:  return 32'(act1 && mrd[k]);
        endcase
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
        end
    endtask

    // Compare and model-advance process, once per cycle on the falling edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            mph[k] = 0; mwin[k] = 1'b0; mrd[k] = 1'b0; maddr[k] = '0; mwd[k] = '0;
            mws[k] = '0; mlast[k] = 1'b1; mown[k] = 1'b0; mpend[k] = '0;
            mrdata[k][0] = '0; mrdata[k][1] = '0;
        end
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++)
                    for (int f = F_BUSY; f <= F_SRSTRB; f++)
                        chk(fname(f), k, act_of(k, f), exp_of(k, f));
                for (int i = 0; i < lit_n; i++)
                    if (lit_cyc[i] == cyc)
                        chk({"lit_", fname(lit_f[i])}, lit_k[i], act_of(lit_k[i], lit_f[i]), lit_v[i]);
            end
            for (int k = 0; k < 2; k++) begin
                logic w;
                if (bd_en && bd_k == k) mmem[k][bd_idx] = bd_val;
                if (mph[k] == 1) begin
                    if (mrd[k]) mpend[k] = mmem[k][maddr[k][7:2]];
                    else for (int b = 0; b < 4; b++)
                        if (mws[k][b]) mmem[k][maddr[k][7:2]][8*b +: 8] = mwd[k][8*b +: 8];
                end
                if (rst) begin
                    mph[k] = 0; mlast[k] = 1'b1; mown[k] = 1'b0;
                    mrdata[k][0] = '0; mrdata[k][1] = '0;
                end else if (mph[k] == 0) begin
                    if (d_req[k][0] || d_req[k][1]) begin
                        if (d_req[k][0] && d_req[k][1]) w = (k == 1) ? 1'b0 : !mlast[k];
                        else w = d_req[k][1];
                        mwin[k] = w; mlast[k] = w; mown[k] = w;
                        maddr[k] = d_addr[k][w]; mwd[k] = d_wdata[k][w]; mws[k] = d_wstrb[k][w];
                        mrd[k] = (d_wstrb[k][w] == 4'b0000);
                        mph[k] = 1;
                    end
                end else if (mph[k] == 2) begin
                    if (mrd[k]) mrdata[k][mwin[k]] = mpend[k];
                    mph[k] = 3;
                end else begin
                    mph[k] = (mph[k] + 1) % 4;
                end
            end
            cyc++;
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic lit(int c, int k, int f, logic [31:0] v);
        lit_cyc[lit_n] = c; lit_k[lit_n] = k; lit_f[lit_n] = f; lit_v[lit_n] = v;
        lit_n++;
    endtask

    task automatic go(int k, int m, logic [31:0] a, logic [31:0] wd, logic [3:0] ws);
        d_addr[k][m] = a; d_wdata[k][m] = wd; d_wstrb[k][m] = ws; d_req[k][m] = 1'b1;
    endtask

    task automatic stop(int k, int m);
        d_req[k][m] = 1'b0;
    endtask

    task automatic bd(int k, logic [31:0] a, logic [31:0] v);
        bd_en = 1'b1; bd_k = k; bd_idx = a[7:2]; bd_val = v;
        tick(1);
        bd_en = 1'b0;
    endtask

    initial begin
        int c;
        rst = 1'b1; bd_en = 1'b0; bd_k = 0; bd_idx = '0; bd_val = '0;
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) begin
                d_req[k][m] = 1'b0; d_addr[k][m] = '0; d_wdata[k][m] = '0; d_wstrb[k][m] = '0;
            end
        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;
        c = cyc;
        lit(c, 0, F_BUSY, 0); lit(c, 0, F_OWNER, 0); lit(c, 0, F_ACK0, 0);
        lit(c, 0, F_RD1, 0); lit(c, 0, F_SRSTRB, 0); lit(c, 1, F_SWSTRB, 0);

        // Single read by m0.
        bd(0, 32'h10, 32'hDEADBEEF);
        c = cyc;
        go(0, 0, 32'h10, 32'h0, 4'b0000);
        lit(c+1, 0, F_SRSTRB, 1); lit(c+1, 0, F_SWSTRB, 0); lit(c+1, 0, F_SADDR, 32'h10);
        lit(c+1, 0, F_BUSY, 1);   lit(c+1, 0, F_OWNER, 0);  lit(c+2, 0, F_SRSTRB, 0);
        lit(c+3, 0, F_ACK0, 1);   lit(c+3, 0, F_RD0, 32'hDEADBEEF); lit(c+3, 0, F_ACK1, 0);
        lit(c+4, 0, F_BUSY, 0);   lit(c+4, 0, F_ACK0, 0);
        tick(3); stop(0, 0); tick(2);

        // Byte write by m1, then read back.
        bd(0, 32'h20, 32'h11223344);
        c = cyc;
        go(0, 1, 32'h20, 32'h000000AA, 4'b0001);
        lit(c+1, 0, F_SWSTRB, 1); lit(c+1, 0, F_SRSTRB, 0); lit(c+2, 0, F_SWSTRB, 0);
        lit(c+3, 0, F_ACK1, 1);   lit(c+3, 0, F_RD1, 0);
        tick(3);
        go(0, 1, 32'h20, 32'h0, 4'b0000);
        lit(c+7, 0, F_ACK1, 1);   lit(c+7, 0, F_RD1, 32'h112233AA);
        tick(4); stop(0, 1); tick(2);

        // Tie after reset under round-robin: grants alternate starting with m0.
        rst = 1'b1; tick(1); rst = 1'b0;
        bd(0, 32'h40, 32'hA0A0A0A0);
        bd(0, 32'h44, 32'hB1B1B1B1);
        c = cyc;
        go(0, 0, 32'h40, 32'h0, 4'b0000);
        go(0, 1, 32'h44, 32'h0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            lit(c+4*i+1, 0, F_OWNER, 32'(i % 2));
            lit(c+4*i+3, 0, F_ACK0, 32'(i % 2 == 0));
            lit(c+4*i+3, 0, F_ACK1, 32'(i % 2 == 1));
        end
        lit(c+3, 0, F_RD0, 32'hA0A0A0A0); lit(c+7, 0, F_RD1, 32'hB1B1B1B1);
        tick(31); stop(0, 0); stop(0, 1); tick(2);

        // Late request: m1 rises during m0's RESP, granted in the following IDLE.
        c = cyc;
        go(0, 0, 32'h10, 32'h0, 4'b0000);
        tick(2);
        go(0, 1, 32'h20, 32'h0, 4'b0000);
        tick(1); stop(0, 0);
        lit(c+3, 0, F_ACK0, 1); lit(c+4, 0, F_BUSY, 0); lit(c+5, 0, F_OWNER, 1);
        lit(c+5, 0, F_BUSY, 1); lit(c+6, 0, F_ACK1, 0); lit(c+7, 0, F_ACK1, 1);
        lit(c+7, 0, F_RD1, 32'h112233AA);
        tick(4); stop(0, 1); tick(2);

        // Reset during RESP of an m0 read: no ack, outputs cleared, next tie goes to m0.
        c = cyc;
        go(0, 0, 32'h10, 32'h0, 4'b0000);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        go(0, 1, 32'h44, 32'h0, 4'b0000);
        lit(c+3, 0, F_ACK0, 0); lit(c+3, 0, F_BUSY, 0); lit(c+3, 0, F_RD0, 0);
        lit(c+3, 0, F_SRSTRB, 0); lit(c+3, 0, F_SADDR, 0); lit(c+3, 0, F_OWNER, 0);
        lit(c+4, 0, F_OWNER, 0); lit(c+4, 0, F_BUSY, 1);
        lit(c+6, 0, F_ACK0, 1);  lit(c+6, 0, F_RD0, 32'hDEADBEEF);
        lit(c+10, 0, F_ACK1, 1); lit(c+10, 0, F_RD1, 32'hB1B1B1B1);
        tick(3); stop(0, 0); tick(4); stop(0, 1); tick(2);

        // Full and partial writes by m0, read back by m1.
        c = cyc;
        go(0, 0, 32'h30, 32'hCAFEF00D, 4'b1111);
        tick(3); stop(0, 0);
        go(0, 1, 32'h30, 32'h0, 4'b0000);
        lit(c+7, 0, F_ACK1, 1); lit(c+7, 0, F_RD1, 32'hCAFEF00D);
        tick(4); stop(0, 1);
        go(0, 0, 32'h30, 32'h12340000, 4'b1100);
        lit(c+9, 0, F_SWSTRB, 32'hC); lit(c+11, 0, F_RD0, 32'hDEADBEEF);
        tick(4); stop(0, 0);
        go(0, 1, 32'h30, 32'h0, 4'b0000);
        lit(c+15, 0, F_ACK1, 1); lit(c+15, 0, F_RD1, 32'h1234F00D);
        tick(4); stop(0, 1); tick(2);

        // Fixed priority: m0 wins every tie, m1 served once m0 drops.
        bd(1, 32'h40, 32'h5555AAAA);
        bd(1, 32'h44, 32'h12345678);
        c = cyc;
        go(1, 0, 32'h40, 32'h0, 4'b0000);
        go(1, 1, 32'h44, 32'h0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            lit(c+4*i+1, 1, F_OWNER, 0);
            lit(c+4*i+3, 1, F_ACK0, 1);
            lit(c+4*i+3, 1, F_ACK1, 0);
        end
        lit(c+3, 1, F_RD0, 32'h5555AAAA);
        tick(15); stop(1, 0);
        lit(c+17, 1, F_OWNER, 1); lit(c+19, 1, F_ACK1, 1); lit(c+19, 1, F_RD1, 32'h12345678);
        tick(4); stop(1, 1); tick(3);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
